enhanced_sync_fifo: RTL

//  Storage end of the FIFO write/read handshake driven by the CPU-side stimulus block.

---
 rtl/enhanced_sync_fifo.sv | 118 +++++++++++
 1 files changed

// File: rtl/enhanced_sync_fifo.sv
// Byte FIFO with occupancy count, almost-full/almost-empty flags and overflow/underflow pulses.
// Latency: read data registered, valid 1 clock after the sampled RD_EN edge; flags valid 1 clock after the edge.
// Backpressure: writes while FULL are dropped (OVERFLOW pulse); reads while EMPTY are dropped (UNDERFLOW pulse).
//
// Ports:
//   SYSCLK, RST          clock, asynchronous active-high reset
//   WR_EN, FIFO_IN       write strobe and data, one transaction per rising edge with WR_EN high
//   RD_EN                read strobe, one transaction per rising edge with RD_EN high
//   FIFO_OUT, RD_VALID   registered read data (holds last value) and its 1-cycle update pulse
//   FULL, EMPTY          count == DEPTH / count == 0
//   ALMOST_FULL          count >= AF_LEVEL
//   ALMOST_EMPTY         count <= AE_LEVEL
//   DATA_COUNT           occupancy 0..DEPTH
//   OVERFLOW, UNDERFLOW  1-cycle pulses for rejected write / rejected read
module enhanced_sync_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              SYSCLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [DATA_W-1:0] FIFO_IN,
  input  logic              RD_EN,
  output logic [DATA_W-1:0] FIFO_OUT,
  output logic              RD_VALID,
  output logic              FULL,
  output logic              EMPTY,
  output logic              ALMOST_FULL,
  output logic              ALMOST_EMPTY,
  output logic [ADDR_W:0]   DATA_COUNT,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   AE_C    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W:0]   next_count;

  // FULL/EMPTY are registered from the count, so they always describe the
  // occupancy seen at this edge. Using them here makes full+both reject the
  // write and empty+both reject the read (no fall-through).
  assign wr_acc = WR_EN & ~FULL;
  assign rd_acc = RD_EN & ~EMPTY;

  always_comb begin
    next_count = DATA_COUNT;
    case ({wr_acc, rd_acc})
      2'b10:   next_count = DATA_COUNT + CNT_ONE;
      2'b01:   next_count = DATA_COUNT - CNT_ONE;
      default: next_count = DATA_COUNT;
    endcase
  end

  // Storage has no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge SYSCLK) begin
    if (wr_acc) begin
      mem[wr_ptr] <= FIFO_IN;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Read data path and single-cycle status pulses.
  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      FIFO_OUT  <= '0;
      RD_VALID  <= 1'b0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      RD_VALID  <= rd_acc;
      OVERFLOW  <= WR_EN & FULL;
      UNDERFLOW <= RD_EN & EMPTY;
      if (rd_acc) begin
        FIFO_OUT <= mem[rd_ptr];
      end
    end
  end

  // Occupancy and flags, all derived from the post-edge count.
  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      DATA_COUNT   <= '0;
      FULL         <= 1'b0;
      EMPTY        <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
    end else begin
      DATA_COUNT   <= next_count;
      FULL         <= (next_count == DEPTH_C);
      EMPTY        <= (next_count == '0);
      ALMOST_FULL  <= (next_count >= AF_C);
      ALMOST_EMPTY <= (next_count <= AE_C);
    end
  end

endmodule
